// File: rtl/vga_timing_pkg.sv
// Timing constants, FSM encoding and helpers shared by the
// VGA capture front end and its sync edge detectors.
package vga_timing_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = 800;

  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = 525;

  localparam int V_ROW_OFFSET = V_SYNC + V_BACK - 1;

  typedef logic [1:0] state_t;

  localparam state_t ST_SEARCH  = 2'd0;
  localparam state_t ST_MEASURE = 2'd1;
  localparam state_t ST_LOCKED  = 2'd2;

  function automatic logic [9:0] sat_inc(
    input logic [9:0] v
  );
    return (v == 10'h3ff) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Registers one active-low sync line and flags its falling edge
// from the registered sample versus the one before it.
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sync,
  output logic fall
);

  logic level;
  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b1;
      prev  <= 1'b1;
    end else begin
      level <= sync;
      prev  <= level;
    end
  end

  assign fall = prev & ~level;

endmodule

// File: rtl/vga_capture.sv
// Recovers raster position from raw VGA syncs and emits captured
// pixels with coordinates once the source timing is locked.
module vga_capture
  import vga_timing_pkg::*;
#(
  parameter int H_ACT   = H_VISIBLE,
  parameter int H_START = H_SYNC + H_BACK,
  parameter int H_LEN   = H_TOTAL,
  parameter int V_ACT   = V_VISIBLE,
  parameter int V_START = V_ROW_OFFSET,
  parameter int V_LEN   = V_TOTAL
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hsync,
  input  logic       vsync,
  input  logic [3:0] red,
  input  logic [3:0] green,
  input  logic [3:0] blue,
  output logic [3:0] pix_red,
  output logic [3:0] pix_green,
  output logic [3:0] pix_blue,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       pixel_valid,
  output logic       frame_start,
  output logic       locked,
  output logic       sync_err
);

  localparam logic [9:0] H_LO    = 10'(H_START);
  localparam logic [9:0] H_HI    = 10'(H_START + H_ACT);
  localparam logic [9:0] H_LAST  = 10'(H_LEN - 1);
  localparam logic [9:0] V_LO    = 10'(V_START);
  localparam logic [9:0] V_HI    = 10'(V_START + V_ACT);
  localparam logic [9:0] V_CNT   = 10'(V_LEN);
  localparam logic [9:0] CNT_MAX = 10'h3ff;

  logic hfall;
  logic vfall;

  sync_edge_detect u_hs (
    .clk   (clk),
    .rst_n (rst_n),
    .sync  (hsync),
    .fall  (hfall)
  );

  sync_edge_detect u_vs (
    .clk   (clk),
    .rst_n (rst_n),
    .sync  (vsync),
    .fall  (vfall)
  );

  logic [11:0] rgb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= {red, green, blue};
    end
  end

  state_t     state;
  state_t     state_nxt;
  logic [9:0] hcnt;
  logic [9:0] hcnt_nxt;
  logic [9:0] vline;
  logic [9:0] vline_nxt;
  logic [9:0] hfalls;
  logic [9:0] hfalls_nxt;
  logic       vpend;
  logic       bad;
  logic       bad_nxt;
  logic       iv_bad;
  logic       runaway;
  logic       lines_ok;
  logic       err;

  // Counter values here belong to the sample now in the input
  // registers, so a detected fall marks that sample as column 0.
  always_comb begin
    hcnt_nxt = hfall ? '0 : sat_inc(hcnt);
    vline_nxt = vline;
    if (hfall) begin
      vline_nxt = (vfall || vpend) ? '0 : sat_inc(vline);
    end
    hfalls_nxt = hfalls;
    if (vfall) begin
      hfalls_nxt = {9'd0, hfall};
    end else if (hfall) begin
      hfalls_nxt = sat_inc(hfalls);
    end
    iv_bad   = hfall && (hcnt != H_LAST);
    runaway  = (hcnt_nxt == CNT_MAX);
    lines_ok = (hfalls == V_CNT);
    bad_nxt  = vfall ? 1'b0 : (bad || iv_bad || runaway);
  end

  // A measurement window opens at a vsync fall; the line that
  // closes on the next vsync fall is still judged for that window.
  always_comb begin
    state_nxt = state;
    err       = 1'b0;
    unique case (1'b1)
      (state == ST_SEARCH): begin
        if (vfall) begin
          state_nxt = ST_MEASURE;
        end
      end
      (state == ST_MEASURE): begin
        if (vfall && lines_ok && !bad && !iv_bad && !runaway) begin
          state_nxt = ST_LOCKED;
        end
      end
      (state == ST_LOCKED): begin
        if (iv_bad || runaway || (vfall && !lines_ok)) begin
          state_nxt = ST_SEARCH;
          err       = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_SEARCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_SEARCH;
      hcnt   <= '0;
      vline  <= '0;
      hfalls <= '0;
      vpend  <= 1'b0;
      bad    <= 1'b0;
    end else begin
      state  <= state_nxt;
      hcnt   <= hcnt_nxt;
      vline  <= vline_nxt;
      hfalls <= hfalls_nxt;
      bad    <= bad_nxt;
      if (vfall) begin
        vpend <= !hfall;
      end else if (hfall) begin
        vpend <= 1'b0;
      end
    end
  end

  logic       h_vis;
  logic       v_vis;
  logic       valid_nxt;
  logic [9:0] x_nxt;
  logic [9:0] y_nxt;

  always_comb begin
    h_vis     = (hcnt_nxt >= H_LO) && (hcnt_nxt < H_HI);
    v_vis     = (vline_nxt >= V_LO) && (vline_nxt < V_HI);
    valid_nxt = (state_nxt == ST_LOCKED) && h_vis && v_vis;
    x_nxt     = hcnt_nxt - H_LO;
    y_nxt     = vline_nxt - V_LO;
  end

  // Gating on the next state drops pixel_valid in the same output
  // cycle that reports the loss of lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_red     <= '0;
      pix_green   <= '0;
      pix_blue    <= '0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      pixel_valid <= 1'b0;
      frame_start <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      pixel_valid <= valid_nxt;
      frame_start <= valid_nxt && (x_nxt == '0) && (y_nxt == '0);
      pixel_x     <= valid_nxt ? x_nxt : '0;
      pixel_y     <= valid_nxt ? y_nxt : '0;
      pix_red     <= valid_nxt ? rgb_q[11:8] : '0;
      pix_green   <= valid_nxt ? rgb_q[7:4] : '0;
      pix_blue    <= valid_nxt ? rgb_q[3:0] : '0;
      sync_err    <= err;
    end
  end

  assign locked = (state == ST_LOCKED);

endmodule

// File: tb/tb_vga_capture.sv
// Scoreboard bench for vga_capture using a reduced raster so whole
// frames, lock, loss of lock and relock fit in a short run.
module tb_vga_capture;

  localparam int HA  = 16;
  localparam int HF  = 4;
  localparam int HS  = 8;
  localparam int HB  = 4;
  localparam int HT  = HA + HF + HS + HB;
  localparam int VA  = 12;
  localparam int VF  = 2;
  localparam int VS  = 2;
  localparam int VB  = 3;
  localparam int VT  = VA + VF + VS + VB;
  localparam int HST = HS + HB;
  localparam int VRO = VS + VB - 1;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       hsync = 1'b1;
  logic       vsync = 1'b1;
  logic [3:0] red   = '0;
  logic [3:0] green = '0;
  logic [3:0] blue  = '0;
  logic [3:0] pix_red;
  logic [3:0] pix_green;
  logic [3:0] pix_blue;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       pixel_valid;
  logic       frame_start;
  logic       locked;
  logic       sync_err;

  vga_capture #(
    .H_ACT   (HA),
    .H_START (HST),
    .H_LEN   (HT),
    .V_ACT   (VA),
    .V_START (VRO),
    .V_LEN   (VT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hsync       (hsync),
    .vsync       (vsync),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .pix_red     (pix_red),
    .pix_green   (pix_green),
    .pix_blue    (pix_blue),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .pixel_valid (pixel_valid),
    .frame_start (frame_start),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [11:0] rgb;
    logic        fs;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks     = 0;
  int   errors     = 0;
  int   err_pulses = 0;
  int   valid_cnt  = 0;
  int   fs_cnt     = 0;
  bit   prev_good  = 1'b0;

  always @(negedge clk) begin
    if (sync_err) begin
      err_pulses++;
      checks++;
      if (pixel_valid) begin
        errors++;
        $display("FAIL valid_on_err: pixel_valid=1 with sync_err, required 0");
      end
    end
    if (pixel_valid) begin
      valid_cnt++;
      if (frame_start) fs_cnt++;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL extra_pixel: x=%0d y=%0d valid, required no pixel",
                 pixel_x, pixel_y);
      end else begin
        e = q.pop_front();
        if ({pixel_x, pixel_y, pix_red, pix_green, pix_blue, frame_start} !== e) begin
          errors++;
          $display("FAIL pixel: got x=%0d y=%0d rgb=%h%h%h fs=%b, required x=%0d y=%0d rgb=%h fs=%b",
                   pixel_x, pixel_y, pix_red, pix_green, pix_blue, frame_start,
                   e.x, e.y, e.rgb, e.fs);
        end
      end
    end else begin
      checks++;
      if ({pix_red, pix_green, pix_blue, frame_start} !== 13'd0) begin
        errors++;
        $display("FAIL idle_out: rgb=%h%h%h fs=%b without pixel_valid, required 0",
                 pix_red, pix_green, pix_blue, frame_start);
      end
    end
  end

  task automatic check_zero(input string name);
    checks++;
    if ({pix_red, pix_green, pix_blue, pixel_x, pixel_y,
         pixel_valid, frame_start, locked, sync_err} !== '0) begin
      errors++;
      $display("FAIL %s: outputs rgb=%h%h%h x=%0d y=%0d v=%b fs=%b lk=%b se=%b, required all 0",
               name, pix_red, pix_green, pix_blue, pixel_x, pixel_y,
               pixel_valid, frame_start, locked, sync_err);
    end
  endtask

  // A frame is locked exactly when the frame before it was seen from
  // its vsync fall with no reset and had clean line lengths and count.
  task automatic run_frame(input int nlines, input int bad_line,
                           input int bad_len, input int rst_line);
    bit   lock_now;
    bit   alive;
    bit   vis;
    bit   rst_done;
    bit   clean;
    bit   exp_lk;
    int   len;
    int   rst_wait;
    int   x;
    int   y;
    int   e0;
    int   v0;
    int   f0;
    int   exp_err;
    exp_t it;
    lock_now = prev_good;
    rst_done = 1'b0;
    rst_wait = 0;
    e0 = err_pulses;
    v0 = valid_cnt;
    f0 = fs_cnt;
    for (int l = 0; l < nlines; l++) begin
      len = (l == bad_line) ? bad_len : HT;
      for (int c = 0; c < len; c++) begin
        @(posedge clk);
        #1;
        if (rst_done && rst_wait < 3) begin
          rst_wait++;
          if (rst_wait == 3) rst_n = 1'b1;
        end
        hsync = (c >= HS);
        vsync = (l >= VS);
        vis = (c >= HST) && (c < HST + HA) && (l >= VRO) && (l < VRO + VA);
        x = c - HST;
        y = l - VRO;
        if (vis) begin
          red   = x[3:0];
          green = y[3:0];
          blue  = x[7:4];
        end else begin
          {red, green, blue} = 12'($urandom);
        end
        alive = !rst_done && (bad_line < 0 || l <= bad_line);
        if (lock_now && alive && vis) begin
          it.x   = 10'(x);
          it.y   = 10'(y);
          it.rgb = {x[3:0], y[3:0], x[7:4]};
          it.fs  = (x == 0) && (y == 0);
          q.push_back(it);
        end
        if (l == rst_line && c == HST + 3) begin
          #1 rst_n = 1'b0;
          q.delete();
          rst_done = 1'b1;
          #1 check_zero("reset_mid");
        end
      end
    end
    clean   = (nlines == VT) && (bad_line < 0);
    exp_err = (lock_now && bad_line >= 0 && rst_line < 0) ? 1 : 0;
    exp_lk  = lock_now && (bad_line < 0) && (rst_line < 0);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d pixels never output, required 0", q.size());
      q.delete();
    end
    checks++;
    if (err_pulses - e0 != exp_err) begin
      errors++;
      $display("FAIL sync_err_count: got %0d pulses, required %0d",
               err_pulses - e0, exp_err);
    end
    checks++;
    if (locked !== exp_lk) begin
      errors++;
      $display("FAIL locked_end: got %b, required %b", locked, exp_lk);
    end
    if (lock_now && clean && rst_line < 0) begin
      checks++;
      if (valid_cnt - v0 != HA * VA || fs_cnt - f0 != 1) begin
        errors++;
        $display("FAIL frame_totals: got %0d pixels %0d starts, required %0d pixels 1 start",
                 valid_cnt - v0, fs_cnt - f0, HA * VA);
      end
    end
    prev_good = clean && (rst_line < 0);
  endtask

  initial begin
    rst_n = 1'b0;
    #2 check_zero("reset_state");
    #20 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    run_frame(VT, -1, 0, -1);
    run_frame(VT, -1, 0, -1);
    run_frame(VT, -1, 0, -1);
    run_frame(VT, $urandom_range(VRO, VRO + VA - 2), HT + 1, -1);
    run_frame(VT, -1, 0, -1);
    run_frame(VT, -1, 0, -1);
    run_frame(VT, $urandom_range(VRO, VRO + VA - 2), HS + 1100, -1);
    run_frame(VT, -1, 0, -1);
    run_frame(VT, -1, 0, -1);
    run_frame(VT, -1, 0, $urandom_range(VRO, VRO + VA - 1));
    run_frame(VT - 1, -1, 0, -1);
    run_frame(VT, -1, 0, -1);
    run_frame(VT, -1, 0, -1);
    for (int i = 0; i < 6; i++) begin
      case ($urandom_range(0, 2))
        0: run_frame(VT, -1, 0, -1);
        1: run_frame(VT, $urandom_range(VRO, VRO + VA - 2), HT - 1, -1);
        default: run_frame(VT, $urandom_range(VRO, VRO + VA - 2), HT + 1, -1);
      endcase
    end
    run_frame(VT, -1, 0, -1);
    run_frame(VT, -1, 0, -1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
